// File: rtl/sram_mp.sv
// Purpose : parametrised multi-port SRAM with per-byte write enables, self-clearing init.
// Latency : 1 cycle read (address at edge N, rdata_o/rvalid_o valid during cycle N+1).
// Backpressure: none; every port accepts one access per cycle once init_done_o is high.
//
// Ports:
//   clk_i, rst_ni        rising-edge clock, asynchronous active-low reset
//   init_done_o          high once every entry has been cleared to zero after reset
//   we_i/waddr_i/wdata_i/wbe_i   NUM_WRITE write ports, byte-granular enables
//   re_i/raddr_i         NUM_READ read ports
//   rdata_o/rvalid_o     registered read data, valid strobe for the cycle after a read
//
// Build option: define SRAM_MP_BYPASS_EN for write-first behaviour on a same-cycle
// read/write hit; leave it undefined for read-first (no forwarding logic is built).
//
// Write conflicts resolve per byte: the highest-indexed write port wins a lane,
// disjoint lanes from different ports all land. The array itself has no reset; after
// reset the INIT state sweeps every entry to zero, one entry per cycle, and accesses
// are ignored until that sweep completes.

module sram_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_READ   = 2,
    parameter int NUM_WRITE  = 1
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    output logic                                          init_done_o,
    input  logic [NUM_WRITE-1:0]                          we_i,
    input  logic [NUM_WRITE-1:0][ADDR_WIDTH-1:0]          waddr_i,
    input  logic [NUM_WRITE-1:0][DATA_WIDTH-1:0]          wdata_i,
    input  logic [NUM_WRITE-1:0][DATA_WIDTH/8-1:0]        wbe_i,
    input  logic [NUM_READ-1:0]                           re_i,
    input  logic [NUM_READ-1:0][ADDR_WIDTH-1:0]           raddr_i,
    output logic [NUM_READ-1:0][DATA_WIDTH-1:0]           rdata_o,
    output logic [NUM_READ-1:0]                           rvalid_o
);

    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam int NUM_BYTES = DATA_WIDTH / 8;

    // Catch illegal configurations at elaboration rather than in silicon.
    if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
        $error("sram_mp: DATA_WIDTH must be a multiple of 8");
    end
    if (NUM_READ < 1 || NUM_WRITE < 1) begin : g_bad_ports
        $error("sram_mp: NUM_READ and NUM_WRITE must be at least 1");
    end

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                                   state;
    logic [ADDR_WIDTH-1:0]                    init_cnt;
    logic [DATA_WIDTH-1:0]                    mem [DEPTH];
    logic [NUM_READ-1:0][DATA_WIDTH-1:0]      rd_word;

    // ------------------------------------------------------------------
    // Read word selection. The raw array word is always the base; with
    // forwarding enabled, same-cycle writes to the same address overlay
    // their enabled bytes in ascending port order so the last (highest)
    // port wins, exactly like the array update below.
    // ------------------------------------------------------------------
    always_comb begin
        rd_word = '0;
        for (int r = 0; r < NUM_READ; r++) begin
            rd_word[r] = mem[raddr_i[r]];
`ifdef SRAM_MP_BYPASS_EN
            for (int w = 0; w < NUM_WRITE; w++) begin
                for (int b = 0; b < NUM_BYTES; b++) begin
                    if (we_i[w] && wbe_i[w][b] && (waddr_i[w] == raddr_i[r])) begin
                        rd_word[r][8*b +: 8] = wdata_i[w][8*b +: 8];
                    end
                end
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // Array update. No reset on the storage: the INIT sweep provides the
    // known-zero state. During INIT the counter entry is cleared and the
    // user write ports are ignored. In READY, ports are applied in
    // ascending order so a higher port's byte overrides a lower one.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (state == INIT) begin
            mem[init_cnt] <= '0;
        end else begin
            for (int w = 0; w < NUM_WRITE; w++) begin
                for (int b = 0; b < NUM_BYTES; b++) begin
                    if (we_i[w] && wbe_i[w][b]) begin
                        mem[waddr_i[w]][8*b +: 8] <= wdata_i[w][8*b +: 8];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs. INIT lasts exactly DEPTH
    // cycles: the edge that clears the last entry also raises
    // init_done_o, so the first user access lands on the following edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= INIT;
            init_cnt    <= '0;
            init_done_o <= 1'b0;
            rvalid_o    <= '0;
            rdata_o     <= '0;
        end else begin
            case (state)
                INIT: begin
                    rvalid_o <= '0;
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == {ADDR_WIDTH{1'b1}}) begin
                        state       <= READY;
                        init_done_o <= 1'b1;
                    end
                end
                READY: begin
                    init_done_o <= 1'b1;
                    for (int r = 0; r < NUM_READ; r++) begin
                        rvalid_o[r] <= re_i[r];
                        // rdata_o holds its last value on idle cycles.
                        if (re_i[r]) begin
                            rdata_o[r] <= rd_word[r];
                        end
                    end
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_mp.sv
// Purpose : self-checking bench for sram_mp (2 read, 2 write ports, 256 x 32).
// Latency : reads scored one cycle after issue via an expected-data queue.
// Backpressure: none; stimulus is applied every cycle.

module tb_sram_mp;

    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int NR    = 2;
    localparam int NW    = 2;
    localparam int DEPTH = 256;

    logic                    clk   = 1'b0;
    logic                    rst_n = 1'b1;
    logic                    init_done;
    logic [NW-1:0]           we;
    logic [NW-1:0][AW-1:0]   waddr;
    logic [NW-1:0][DW-1:0]   wdata;
    logic [NW-1:0][3:0]      wbe;
    logic [NR-1:0]           re;
    logic [NR-1:0][AW-1:0]   raddr;
    logic [NR-1:0][DW-1:0]   rdata;
    logic [NR-1:0]           rvalid;

    int n_checks = 0;
    int n_fail   = 0;
    int edges    = 0;

    logic [DW-1:0]           model_mem [DEPTH];
    logic [NR-1:0]           exp_vld;
    logic [NR-1:0][DW-1:0]   exp_rdata;

    typedef struct packed {
        logic [7:0]    port;
        logic [DW-1:0] data;
    } sb_t;
    sb_t sb_q[$];

    sram_mp #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_READ   (NR),
        .NUM_WRITE  (NW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .init_done_o (init_done),
        .we_i        (we),
        .waddr_i     (waddr),
        .wdata_i     (wdata),
        .wbe_i       (wbe),
        .re_i        (re),
        .raddr_i     (raddr),
        .rdata_o     (rdata),
        .rvalid_o    (rvalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        we    = '0;
        waddr = '0;
        wdata = '0;
        wbe   = '0;
        re    = '0;
        raddr = '0;
    endtask

    task automatic set_write(input int p, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [3:0] be);
        we[p]    = 1'b1;
        waddr[p] = a;
        wdata[p] = d;
        wbe[p]   = be;
    endtask

    task automatic set_read(input int p, input logic [AW-1:0] a);
        re[p]    = 1'b1;
        raddr[p] = a;
    endtask

    // Expected read value for port r under the current inputs.
    function automatic logic [DW-1:0] model_read(input int r);
        logic [DW-1:0] v;
        v = model_mem[raddr[r]];
`ifdef SRAM_MP_BYPASS_EN
        for (int w = 0; w < NW; w++)
            for (int b = 0; b < 4; b++)
                if (we[w] && wbe[w][b] && waddr[w] == raddr[r])
                    v[8*b +: 8] = wdata[w][8*b +: 8];
`endif
        return v;
    endfunction

    task automatic model_write();
        for (int w = 0; w < NW; w++)
            for (int b = 0; b < 4; b++)
                if (we[w] && wbe[w][b])
                    model_mem[waddr[w]][8*b +: 8] = wdata[w][8*b +: 8];
    endtask

    // One clock: predict, push expectations, clock, then score outputs.
    task automatic tick();
        logic ready;
        sb_t  e;
        ready   = (edges >= DEPTH);
        exp_vld = '0;
        if (ready) begin
            for (int r = 0; r < NR; r++) begin
                if (re[r]) begin
                    exp_vld[r]   = 1'b1;
                    exp_rdata[r] = model_read(r);
                    sb_q.push_back('{port: 8'(r), data: exp_rdata[r]});
                end
            end
            model_write();
        end else begin
            model_mem[edges[AW-1:0]] = '0;
        end
        @(posedge clk);
        #1;
        edges++;
        check("init_done", 32'(init_done), 32'(edges >= DEPTH));
        for (int r = 0; r < NR; r++) begin
            check($sformatf("rvalid%0d", r), 32'(rvalid[r]), 32'(exp_vld[r]));
            if (rvalid[r]) begin
                check($sformatf("sb_nonempty%0d", r), 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check($sformatf("sb_port%0d", r), 32'(e.port), 32'(r));
                    check($sformatf("sb_data%0d", r), rdata[r], e.data);
                end
            end
            check($sformatf("rdata_hold%0d", r), rdata[r], exp_rdata[r]);
        end
    endtask

    task automatic apply_reset();
        idle();
        rst_n = 1'b0;
        #2;
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata0", rdata[0], 32'd0);
        check("rst_rdata1", rdata[1], 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n     = 1'b1;
        edges     = 0;
        exp_vld   = '0;
        exp_rdata = '0;
        sb_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] rdw_exp;
        idle();
        #1;
        apply_reset();

        // Partial init with a read pulse that must be ignored.
        for (int i = 0; i < 50; i++) tick();
        set_read(0, 8'h05);
        set_read(1, 8'h06);
        tick();
        check("init_read_ignored", 32'(rvalid), 32'd0);
        idle();
        while (edges < 100) tick();

        // Reset mid-init; full DEPTH-cycle init must restart.
        apply_reset();
        for (int i = 0; i < DEPTH - 1; i++) tick();
        check("init_lo_255", 32'(init_done), 32'd0);
        tick();
        check("init_hi_256", 32'(init_done), 32'd1);

        // Cleared contents.
        set_read(0, 8'h00);
        set_read(1, 8'h7F);
        tick();
        check("zero_00", rdata[0], 32'h0000_0000);
        check("zero_7f", rdata[1], 32'h0000_0000);
        check("zero_vld", 32'(rvalid), 32'h3);
        idle();
        set_read(0, 8'hFF);
        tick();
        check("zero_ff", rdata[0], 32'h0000_0000);

        // Byte enables.
        idle(); set_write(0, 8'h10, 32'hDEADBEEF, 4'hF); tick();
        idle(); set_write(0, 8'h10, 32'h00001234, 4'h3); tick();
        idle(); set_read(0, 8'h10); tick();
        check("byte_en", rdata[0], 32'hDEAD1234);

        // Write conflicts: full word, then single-lane override.
        idle();
        set_write(0, 8'h20, 32'h11111111, 4'hF);
        set_write(1, 8'h20, 32'h22222222, 4'hF);
        tick();
        idle(); set_read(1, 8'h20); tick();
        check("conflict_full", rdata[1], 32'h22222222);
        idle();
        set_write(0, 8'h20, 32'h11111111, 4'hF);
        set_write(1, 8'h20, 32'h22222222, 4'h1);
        tick();
        idle(); set_read(0, 8'h20); tick();
        check("conflict_lane", rdata[0], 32'h11111122);

        // Read during write.
        idle(); set_write(0, 8'h30, 32'hAAAAAAAA, 4'hF); tick();
        idle(); set_write(1, 8'h30, 32'h55555555, 4'hF); set_read(0, 8'h30); tick();
`ifdef SRAM_MP_BYPASS_EN
        rdw_exp = 32'h55555555;
`else
        rdw_exp = 32'hAAAAAAAA;
`endif
        check("rdw_same", rdata[0], rdw_exp);
        idle(); set_read(0, 8'h30); tick();
        check("rdw_next", rdata[0], 32'h55555555);

        // Multi-read then hold.
        idle(); set_write(0, 8'h40, 32'h12345678, 4'hF); tick();
        idle(); set_read(0, 8'h40); set_read(1, 8'h40); tick();
        check("multi0", rdata[0], 32'h12345678);
        check("multi1", rdata[1], 32'h12345678);
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold0", rdata[0], 32'h12345678);
            check("hold1", rdata[1], 32'h12345678);
            check("hold_vld", 32'(rvalid), 32'd0);
        end

        // Random traffic on a small address window to force collisions.
        for (int i = 0; i < 400; i++) begin
            idle();
            for (int w = 0; w < NW; w++)
                if ($urandom_range(0, 1) == 1)
                    set_write(w, 8'($urandom_range(128, 135)), $urandom,
                              4'($urandom_range(0, 15)));
            for (int r = 0; r < NR; r++)
                if ($urandom_range(0, 2) != 0)
                    set_read(r, 8'($urandom_range(128, 135)));
            tick();
        end

        idle();
        tick();
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
